pc_fetch_unit: RTL and testbench

Fetch-side consumer of the next-PC logic. It owns the architectural PC register, fetches the instruction word at PC from instruction memory over a req/ack handshake, and presents it to the core with a valid/done handshake. When the core finishes the instruction, it loads the core-computed next PC. It sits between the next-PC computation (branch/jump/jr selection) and the decode stage of the multi-cycle CPU.

---
 rtl/pc_fetch_unit.sv | 91 +++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the architectural PC, reads the instruction at PC over a
// req/ack handshake and holds it in IR until the core reports completion.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic        IR_valid,
  input  logic        instr_done,
  input  logic [31:0] PC_next_in,
  input  logic        halt,
  input  logic        resume,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] instr_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    misalign_d = 1'b0;
    count_d    = count_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_done) begin
          // Misalignment is flagged but never stalls: fetch continues word-aligned.
          pc_d       = {PC_next_in[31:2], 2'b00};
          count_d    = count_q + 32'd1;
          misalign_d = |PC_next_in[1:0];
          state_d    = halt ? HALT : FETCH;
        end
      end
      HALT: begin
        if (resume) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign imem_req    = (state_q == FETCH);
  assign IR_valid    = (state_q == ISSUE);
  assign halted      = (state_q == HALT);
  assign PC          = pc_q;
  assign imem_addr   = pc_q;
  assign IR          = ir_q;
  assign misalign    = misalign_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: linear stimulus with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic        IR_valid;
  logic        instr_done;
  logic [31:0] PC_next_in;
  logic        halt;
  logic        resume;
  logic        halted;
  logic        misalign;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC         (PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IR         (IR),
    .IR_valid   (IR_valid),
    .instr_done (instr_done),
    .PC_next_in (PC_next_in),
    .halt       (halt),
    .resume     (resume),
    .halted     (halted),
    .misalign   (misalign),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_ir"}, IR, 32'h0);
    chk({tag, "_irv"}, {31'h0, IR_valid}, 32'h0);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
    chk({tag, "_mis"}, {31'h0, misalign}, 32'h0);
    chk({tag, "_cnt"}, instr_count, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    instr_done = 1'b0;
    PC_next_in = 32'h0;
    halt       = 1'b0;
    resume     = 1'b0;

    tick();
    chk_reset_vals("reset");
    tick();
    rst_n = 1'b1;
    // Cycle 0 after release: IDLE, no request.
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    tick();

    // Back-to-back instructions: zero-wait memory, done in first ISSUE cycle.
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", {31'h0, imem_req}, 32'h1);
      chk("seq_addr", imem_addr, 32'(4 * i));
      imem_ack   = 1'b1;
      imem_rdata = 32'h1000_0000 + 32'(i);
      tick();
      imem_ack = 1'b0;
      chk("seq_irv", {31'h0, IR_valid}, 32'h1);
      chk("seq_ir", IR, 32'h1000_0000 + 32'(i));
      chk("seq_issue_req", {31'h0, imem_req}, 32'h0);
      instr_done = 1'b1;
      PC_next_in = 32'(4 * i + 4);
      tick();
      instr_done = 1'b0;
    end
    chk("seq_count", instr_count, 32'd4);
    chk("seq_mis", {31'h0, misalign}, 32'h0);

    // Memory wait: ack withheld three cycles.
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h0000_0010);
      chk("wait_irv", {31'h0, IR_valid}, 32'h0);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2002_0005;
    chk("ackcyc_irv", {31'h0, IR_valid}, 32'h0);
    tick();
    imem_ack = 1'b0;
    chk("wait_irv_rise", {31'h0, IR_valid}, 32'h1);
    chk("wait_ir", IR, 32'h2002_0005);

    // Stray ack during ISSUE must not touch IR.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_ir", IR, 32'h2002_0005);
    chk("stray_ack_irv", {31'h0, IR_valid}, 32'h1);

    // Redirect from 0x10 to 0x0040_0100.
    chk("redir_pc_before", PC, 32'h0000_0010);
    instr_done = 1'b1;
    PC_next_in = 32'h0040_0100;
    tick();
    instr_done = 1'b0;
    chk("redir_addr", imem_addr, 32'h0040_0100);
    chk("redir_req", {31'h0, imem_req}, 32'h1);
    chk("redir_count", instr_count, 32'd5);

    // Stray done and resume in FETCH must be ignored.
    instr_done = 1'b1;
    resume     = 1'b1;
    PC_next_in = 32'h0000_0999;
    tick();
    instr_done = 1'b0;
    resume     = 1'b0;
    chk("stray_done_addr", imem_addr, 32'h0040_0100);
    chk("stray_done_cnt", instr_count, 32'd5);
    chk("stray_done_req", {31'h0, imem_req}, 32'h1);

    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_00AA;
    tick();
    imem_ack = 1'b0;
    // halt without done is ignored.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_nodone_irv", {31'h0, IR_valid}, 32'h1);
    chk("halt_nodone_halted", {31'h0, halted}, 32'h0);

    // Misaligned target with halt.
    instr_done = 1'b1;
    halt       = 1'b1;
    PC_next_in = 32'h0000_0022;
    tick();
    instr_done = 1'b0;
    halt       = 1'b0;
    chk("halt_pc", PC, 32'h0000_0020);
    chk("halt_mis", {31'h0, misalign}, 32'h1);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_req", {31'h0, imem_req}, 32'h0);
    chk("halt_irv", {31'h0, IR_valid}, 32'h0);
    chk("halt_count", instr_count, 32'd6);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("halt_mis_pulse", {31'h0, misalign}, 32'h0);
    chk("halt_hold", {31'h0, halted}, 32'h1);
    chk("halt_stray_ack_ir", IR, 32'h0000_00AA);
    chk("halt_hold_req", {31'h0, imem_req}, 32'h0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h0000_0020);
    chk("resume_halted", {31'h0, halted}, 32'h0);

    // Counter wrap: preset the counter, then retire one instruction.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_00BB;
    tick();
    imem_ack = 1'b0;
    dut.count_q = 32'hFFFF_FFFF;
    instr_done = 1'b1;
    PC_next_in = 32'h0000_0024;
    tick();
    instr_done = 1'b0;
    chk("wrap_count", instr_count, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0024);

    // Async reset while FETCH awaits ack.
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    rst_n      = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("post_rst_ir", IR, 32'h0);
    chk("post_rst_irv", {31'h0, IR_valid}, 32'h0);
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
